// File: rtl/add16_seq_arb.sv
// Two-port arbiter that streams WIDTH-bit add/sub through a shared
// 16-bit group-PG adder, one slice per cycle, with a rippled carry.
module add16_seq_arb #(
  parameter int WIDTH = 32,
  localparam int NS = WIDTH / 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_id,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_cin,
  input  logic [15:0]      add_s,
  input  logic             add_pg,
  input  logic             add_gg
);

  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_k;
  logic             r_carry;
  logic             r_last;
  logic             r_cout;
  logic             r_ovf;
  logic             r_id;

  logic             w_idle;
  logic             w_run;
  logic             w_g0;
  logic             w_g1;
  logic             w_c;
  logic             w_end;
  logic             w_sub;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [15:0]      w_sa;
  logic [15:0]      w_sb;

  assign w_idle = (r_state == IDLE);
  assign w_run  = (r_state == RUN);

  // A tie goes to whoever did not win last time.
  assign w_g0 = w_idle & req0_valid & (~req1_valid | r_last);
  assign w_g1 = w_idle & req1_valid & (~req0_valid | ~r_last);

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;

  assign w_opa = w_g1 ? req1_a : req0_a;
  assign w_opb = w_g1 ? req1_b : req0_b;
  assign w_sub = w_g1 ? req1_sub : req0_sub;

  assign w_sa = r_a[16*r_k +: 16];
  assign w_sb = r_b[16*r_k +: 16];

  assign add_a   = w_run ? w_sa : '0;
  assign add_b   = w_run ? w_sb : '0;
  assign add_cin = w_run & r_carry;

  assign w_c   = add_gg | (add_pg & r_carry);
  assign w_end = (r_k == CW'(NS - 1));

  assign rsp_valid = (r_state == DONE);
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_ovf   = r_ovf;
  assign rsp_id    = r_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_last  <= 1'b1;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_id    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_g0 | w_g1) begin
            r_a     <= w_opa;
            r_b     <= w_opb ^ {WIDTH{w_sub}};
            r_carry <= w_sub;
            r_id    <= w_g1;
            r_last  <= w_g1;
            r_k     <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[16*r_k +: 16] <= add_s;
          r_carry <= w_c;
          r_k     <= r_k + 1'b1;
          if (w_end) begin
            r_cout  <= w_c;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &
                       (add_s[15] != r_a[WIDTH-1]);
            r_state <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add16_seq_arb.sv
// Bench for add16_seq_arb: behavioural adder, arithmetic reference
// model, directed and random operations.
module tb_add16_seq_arb;

  localparam int W  = 32;
  localparam int NS = W / 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [W-1:0]  req0_a = '0;
  logic [W-1:0]  req0_b = '0;
  logic          req0_sub = 1'b0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [W-1:0]  req1_a = '0;
  logic [W-1:0]  req1_b = '0;
  logic          req1_sub = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_sum;
  logic          rsp_cout;
  logic          rsp_ovf;
  logic          rsp_id;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic          add_cin;
  logic [15:0]   add_s;
  logic          add_pg;
  logic          add_gg;

  int n_chk  = 0;
  int n_fail = 0;
  bit m_last = 1'b1;

  always #5 clk = ~clk;

  add16_seq_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_ovf(rsp_ovf), .rsp_id(rsp_id),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_pg(add_pg), .add_gg(add_gg)
  );

  // Shared 16-bit adder slice
  logic [16:0] t_full;
  logic [16:0] t_gen;
  assign t_full = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  assign t_gen  = {1'b0, add_a} + {1'b0, add_b};
  assign add_s  = t_full[15:0];
  assign add_gg = t_gen[16];
  assign add_pg = &(add_a ^ add_b);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input bit sub);
    longint ua, ub, us, sa, sb, ss;
    logic [W-1:0] s;
    bit c, v;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      us = ua - ub;
      ss = sa - sb;
      c  = (ua >= ub);
    end else begin
      us = ua + ub;
      ss = sa + sb;
      c  = (us >= 64'sh1_0000_0000);
    end
    s = us[W-1:0];
    v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return {v, c, s};
  endfunction

  task automatic drive(input bit id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit sub);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_rsp(input string tag, input bit id,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit sub);
    logic [W+1:0] m;
    m = model(a, b, sub);
    chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, ".sum"},  64'(rsp_sum),  64'(m[W-1:0]));
    chk({tag, ".cout"}, 64'(rsp_cout), 64'(m[W]));
    chk({tag, ".ovf"},  64'(rsp_ovf),  64'(m[W+1]));
    chk({tag, ".id"},   64'(rsp_id),   64'(id));
  endtask

  // Single-requester op; response held for 'hold' cycles before taken
  task automatic run_op(input string tag, input bit id,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sub, input int hold);
    int cyc;
    logic [W+2:0] snap;
    @(negedge clk);
    drive(id, a, b, sub);
    #1;
    chk({tag, ".rdy"}, 64'({req1_ready, req0_ready}),
        id ? 64'd2 : 64'd1);
    m_last = id;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(cyc);
    chk({tag, ".lat"}, 64'(cyc), 64'(NS));
    check_rsp(tag, id, a, b, sub);
    snap = {rsp_ovf, rsp_cout, rsp_id, rsp_sum};
    for (int i = 0; i < hold; i++) begin
      drive(!id, a, b, sub);
      @(negedge clk);
      chk({tag, ".hold"}, 64'({rsp_valid, rsp_ovf, rsp_cout, rsp_id,
          rsp_sum}), 64'({1'b1, snap}));
      chk({tag, ".hrdy"}, 64'({req1_ready, req0_ready}), 64'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".idle"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int cyc;
    bit exp_w;
    logic [W-1:0] a0, b0, a1, b1, ra, rb;
    bit s0, s1, rs, rid;

    #12;
    chk("reset.outs", 64'({req0_ready, req1_ready, rsp_valid, rsp_cout,
        rsp_ovf, rsp_id, add_cin}), 64'd0);
    chk("reset.sum", 64'(rsp_sum), 64'd0);
    chk("reset.add", 64'({add_a, add_b}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("c0", 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 0);
    run_op("c1", 1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    run_op("c2", 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    run_op("c3", 1'b0, 32'h00000000, 32'h00000001, 1'b1, 0);
    run_op("c4", 1'b0, 32'h00000005, 32'h00000003, 1'b1, 0);
    run_op("c5", 1'b0, 32'h80000000, 32'h00000001, 1'b1, 0);
    run_op("hold", 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 3);

    // Back-to-back contention; operands change after each accept
    a0 = $urandom; b0 = $urandom; s0 = 1'($urandom);
    a1 = $urandom; b1 = $urandom; s1 = 1'($urandom);
    drive(1'b0, a0, b0, s0);
    drive(1'b1, a1, b1, s1);
    rsp_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      cyc = 0;
      #1;
      while (!(req0_ready || req1_ready) && cyc < 20) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      exp_w = !m_last;
      chk("arb.rdy", 64'({req1_ready, req0_ready}),
          exp_w ? 64'd2 : 64'd1);
      m_last = exp_w;
      @(negedge clk);
      chk("arb.run", 64'({req1_ready, req0_ready, rsp_valid}), 64'd0);
      wait_rsp(cyc);
      if (exp_w) check_rsp("arb", 1'b1, a1, b1, s1);
      else       check_rsp("arb", 1'b0, a0, b0, s0);
      if (exp_w) begin
        a1 = $urandom; b1 = $urandom; s1 = 1'($urandom);
        drive(1'b1, a1, b1, s1);
      end else begin
        a0 = $urandom; b0 = $urandom; s0 = 1'($urandom);
        drive(1'b0, a0, b0, s0);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);

    // Reset during the first RUN cycle
    drive(1'b1, 32'hDEADBEEF, 32'h11111111, 1'b0);
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst.outs", 64'({req0_ready, req1_ready, rsp_valid, rsp_cout,
        rsp_ovf, rsp_id, add_cin}), 64'd0);
    chk("rst.sum", 64'(rsp_sum), 64'd0);
    chk("rst.add", 64'({add_a, add_b}), 64'd0);
    m_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst.stale", 64'(rsp_valid), 64'd0);
    end
    run_op("rst.new", 1'b0, 32'h0001FFFF, 32'h0000FFFF, 1'b0, 0);

    // Random single-requester ops
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom); rid = 1'($urandom);
      run_op("rnd", rid, ra, rb, rs, i % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
